fpu_cmd_seq: RTL and testbench

//  Command sequencer upstream of the fpu top: queues {op,src1,src2,dst} commands, drives fpu enable/ld/opcode/addr1-3,

---
 rtl/fpu_cmd_seq.sv | 167 ++++++++++++++++
 tb/tb_fpu_cmd_seq.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_cmd_seq.sv
// Command sequencer for the fpu: a small FIFO of {op,src1,src2,dst} commands and an FSM
// that walks each command through read -> load -> execute -> respond on the fpu SRAM port.
module fpu_cmd_seq #(
    parameter int         DEPTH        = 4,
    parameter int         TIMEOUT      = 15,
    parameter logic [4:0] SCRATCH_ADDR = 5'd31
) (
    input  logic        clk,
    input  logic        taprst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [4:0]  cmd_src1,
    input  logic [4:0]  cmd_src2,
    input  logic [4:0]  cmd_dst,
    output logic        fpu_enable,
    output logic        fpu_ld,
    output logic [2:0]  fpu_opcode,
    output logic [4:0]  fpu_addr1,
    output logic [4:0]  fpu_addr2,
    output logic [4:0]  fpu_addr3,
    output logic [31:0] fpu_inp,
    input  logic        fpu_done,
    input  logic [31:0] fpu_out,
    input  logic [4:0]  fpu_flags,
    input  logic [2:0]  fpu_cmp,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic [5:0]  rsp_flags,
    output logic [2:0]  rsp_cmp,
    input  logic        sticky_clr,
    output logic [5:0]  sticky_flags,
    output logic        busy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_LOAD, S_EXEC, S_RESP} state_t;

    state_t         state_q, state_d;
    logic [17:0]    mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q;
    logic [17:0]    cur_q, cur_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [31:0]    rsp_data_q, rsp_data_d;
    logic [5:0]     rsp_flags_q, rsp_flags_d;
    logic [2:0]     rsp_cmp_q, rsp_cmp_d;
    logic [5:0]     sticky_q, sticky_d;
    logic           push, pop;
    logic [2:0]     head_op;

    assign cmd_ready = (count_q != CW'(DEPTH));
    assign push      = cmd_valid & cmd_ready;
    assign head_op   = mem_q[rd_ptr_q][17:15];
    assign busy      = (state_q != S_IDLE) || (count_q != '0);
    assign fpu_inp   = '0;

    assign rsp_data     = rsp_data_q;
    assign rsp_flags    = rsp_flags_q;
    assign rsp_cmp      = rsp_cmp_q;
    assign sticky_flags = sticky_q;

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {cmd_op, cmd_src1, cmd_src2, cmd_dst};
    end

    always_ff @(posedge clk or negedge taprst) begin
        if (!taprst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cur_q       <= '0;
            timer_q     <= '0;
            rsp_data_q  <= '0;
            rsp_flags_q <= '0;
            rsp_cmp_q   <= '0;
            sticky_q    <= '0;
        end else begin
            state_q     <= state_d;
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q     <= count_q + CW'(push) - CW'(pop);
            cur_q       <= cur_d;
            timer_q     <= timer_d;
            rsp_data_q  <= rsp_data_d;
            rsp_flags_q <= rsp_flags_d;
            rsp_cmp_q   <= rsp_cmp_d;
            sticky_q    <= sticky_d;
        end
    end

    // Clear beats a same-cycle response so software never loses a clear to a race.
    always_comb begin
        sticky_d = sticky_q;
        if (sticky_clr)     sticky_d = '0;
        else if (rsp_valid) sticky_d = sticky_q | rsp_flags_q;
    end

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        cur_d       = cur_q;
        timer_d     = timer_q;
        rsp_data_d  = rsp_data_q;
        rsp_flags_d = rsp_flags_q;
        rsp_cmp_d   = rsp_cmp_q;
        fpu_enable  = 1'b0;
        fpu_ld      = 1'b0;
        fpu_opcode  = '0;
        fpu_addr1   = SCRATCH_ADDR;
        fpu_addr2   = '0;
        fpu_addr3   = '0;
        rsp_valid   = 1'b0;

        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (count_q != '0) begin
                    pop   = 1'b1;
                    cur_d = mem_q[rd_ptr_q];
                    if (head_op <= 3'd4) begin
                        state_d = S_READ;
                    end else begin
                        rsp_data_d  = '0;
                        rsp_flags_d = 6'b001000;
                        rsp_cmp_d   = '0;
                        state_d     = S_RESP;
                    end
                end
            end
            S_READ, S_LOAD, S_EXEC: begin
                fpu_enable = 1'b1;
                fpu_ld     = (state_q == S_LOAD);
                fpu_opcode = cur_q[17:15];
                fpu_addr1  = cur_q[14:10];
                fpu_addr2  = cur_q[9:5];
                fpu_addr3  = cur_q[4:0];
                if (state_q == S_READ) begin
                    state_d = S_LOAD;
                end else if (state_q == S_LOAD) begin
                    timer_d = '0;
                    state_d = S_EXEC;
                end else if (fpu_done) begin
                    rsp_data_d  = fpu_out;
                    rsp_flags_d = {1'b0, fpu_flags};
                    rsp_cmp_d   = (cur_q[17:15] == 3'd0 || cur_q[17:15] == 3'd4) ? fpu_cmp : 3'b000;
                    state_d     = S_RESP;
                end else if (timer_q == TW'(TIMEOUT)) begin
                    rsp_data_d  = '0;
                    rsp_flags_d = 6'b100000;
                    rsp_cmp_d   = '0;
                    state_d     = S_RESP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_fpu_cmd_seq.sv
// Bench for fpu_cmd_seq: behavioural fpu/SRAM stand-in plus an in-order response scoreboard.
module tb_fpu_cmd_seq;
    logic        clk = 1'b0;
    logic        taprst;
    logic        cmd_valid, cmd_ready;
    logic [2:0]  cmd_op;
    logic [4:0]  cmd_src1, cmd_src2, cmd_dst;
    logic        fpu_enable, fpu_ld;
    logic [2:0]  fpu_opcode;
    logic [4:0]  fpu_addr1, fpu_addr2, fpu_addr3;
    logic [31:0] fpu_inp;
    logic        fpu_done;
    logic [31:0] fpu_out;
    logic [4:0]  fpu_flags;
    logic [2:0]  fpu_cmp;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [5:0]  rsp_flags;
    logic [2:0]  rsp_cmp;
    logic        sticky_clr;
    logic [5:0]  sticky_flags;
    logic        busy;

    always #5 clk = ~clk;

    fpu_cmd_seq dut (
        .clk(clk), .taprst(taprst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_src1(cmd_src1), .cmd_src2(cmd_src2), .cmd_dst(cmd_dst),
        .fpu_enable(fpu_enable), .fpu_ld(fpu_ld), .fpu_opcode(fpu_opcode),
        .fpu_addr1(fpu_addr1), .fpu_addr2(fpu_addr2), .fpu_addr3(fpu_addr3), .fpu_inp(fpu_inp),
        .fpu_done(fpu_done), .fpu_out(fpu_out), .fpu_flags(fpu_flags), .fpu_cmp(fpu_cmp),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_flags(rsp_flags), .rsp_cmp(rsp_cmp),
        .sticky_clr(sticky_clr), .sticky_flags(sticky_flags), .busy(busy)
    );

    // fpu stand-in: latches operands on ld, raises done lat cycles into execute, owns the SRAM.
    logic [31:0] sram [32];
    logic [31:0] a_q, b_q;
    logic        loaded;
    int          fcnt, exec_cycles, en_cnt, lat;
    bit          hang;

    always @(posedge clk) begin
        if (!taprst) begin
            for (int i = 0; i < 32; i++) sram[i] <= 32'h0;
            sram[0]  <= 32'h3F80_0000;
            sram[1]  <= 32'h4000_0000;
            sram[4]  <= 32'h4040_0000;
            sram[5]  <= 32'h4080_0000;
            sram[6]  <= 32'h1234_5678;
            sram[13] <= 32'h0BAD_F00D;
            sram[31] <= 32'hDEAD_BEEF;
            loaded <= 1'b0; fcnt <= 0; exec_cycles <= 0;
        end else begin
            if (fpu_enable && fpu_ld) begin
                a_q <= sram[fpu_addr1]; b_q <= sram[fpu_addr2];
                loaded <= 1'b1; fcnt <= 0; exec_cycles <= 0;
            end else if (fpu_enable) begin
                fcnt <= fcnt + 1;
                if (loaded) exec_cycles <= exec_cycles + 1;
            end else begin
                loaded <= 1'b0;
            end
            if (fpu_done) sram[fpu_addr3] <= fpu_out;
            if (!fpu_enable) sram[fpu_addr1] <= fpu_inp;
        end
    end

    always @(posedge clk) if (fpu_enable) en_cnt <= en_cnt + 1;

    assign fpu_done = fpu_enable && !fpu_ld && loaded && !hang && (fcnt == lat);

    always_comb begin
        fpu_out   = 32'hFFFF_FFFF;
        fpu_flags = 5'b0;
        fpu_cmp   = {a_q < b_q, a_q == b_q, a_q > b_q};
        case (fpu_opcode)
            3'd0: if (a_q == 32'h3F80_0000 && b_q == 32'h4000_0000) fpu_out = 32'h4040_0000;
            3'd1: if (a_q == 32'h4000_0000 && b_q == 32'h4040_0000) fpu_out = 32'h40C0_0000;
            3'd2: if (b_q == 32'h0) begin fpu_out = 32'h7F80_0000; fpu_flags = 5'b00001; end
            3'd3: if (a_q == 32'h4080_0000) fpu_out = 32'h4000_0000;
            3'd4: fpu_out = 32'h0;
            default: ;
        endcase
    end

    typedef struct {
        logic [31:0] d;
        logic [5:0]  f;
        logic [2:0]  c;
        int          ex;
        int          gap;
    } exp_t;

    exp_t sb[$];
    int   ncmp = 0, nerr = 0;
    int   cyc = 0, last_rsp = 0, rsp_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rsp_valid) begin
            rsp_cnt  <= rsp_cnt + 1;
            last_rsp <= cyc;
            ncmp++;
            assert (sb.size() > 0) else begin
                nerr++;
                $error("FAIL rsp_unexpected: observed rsp_data %h with empty scoreboard expected none", rsp_data);
            end
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_data", rsp_data, e.d);
                chk("rsp_flags", 32'(rsp_flags), 32'(e.f));
                chk("rsp_cmp", 32'(rsp_cmp), 32'(e.c));
                if (e.ex >= 0)  chk("exec_cycles", 32'(exec_cycles), 32'(e.ex));
                if (e.gap >= 0) chk("rsp_gap", 32'(cyc - last_rsp), 32'(e.gap));
            end
        end
    end

    task automatic push(input logic [2:0] op, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [4:0] d, input logic [31:0] ed, input logic [5:0] ef,
                        input logic [2:0] ec, input int ex, input int gap);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_src1 = s1; cmd_src2 = s2; cmd_dst = d;
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        ncmp++;
        assert (n < 100) else begin
            nerr++;
            $error("FAIL push_ready: observed cmd_ready low for %0d cycles expected high within 100", n);
        end
        e.d = ed; e.f = ef; e.c = ec; e.ex = ex; e.gap = gap;
        sb.push_back(e);
        @(posedge clk);
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge clk);
        cmd_valid = 1'b0;
        while ((sb.size() != 0 || busy) && n < 400) begin @(negedge clk); n++; end
        ncmp++;
        assert (n < 400) else begin
            nerr++;
            $error("FAIL wait_done: observed %0d responses pending after %0d cycles expected 0", sb.size(), n);
        end
    endtask

    initial begin
        int e0, r0;
        taprst = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_src1 = '0; cmd_src2 = '0; cmd_dst = '0;
        sticky_clr = 1'b0; lat = 1; hang = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_addr1", 32'(fpu_addr1), 32'd31);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_enable", 32'(fpu_enable), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_sticky", 32'(sticky_flags), 32'd0);
        @(negedge clk) taprst = 1'b1;

        push(3'd0, 5'd0, 5'd1, 5'd2, 32'h4040_0000, 6'b000000, 3'b100, 2, -1);
        wait_done();
        chk("sram_dst_add", sram[2], 32'h4040_0000);
        chk("sram_scratch", sram[31], 32'h0);

        push(3'd2, 5'd0, 5'd3, 5'd11, 32'h7F80_0000, 6'b000001, 3'b000, 2, -1);
        wait_done();
        chk("sticky_div0", 32'(sticky_flags), 32'h01);

        e0 = en_cnt;
        push(3'd6, 5'd1, 5'd2, 5'd12, 32'h0, 6'b001000, 3'b000, -1, -1);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("illegal_rsp_early", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("illegal_rsp_time", 32'(rsp_valid), 32'd1);
        sticky_clr = 1'b1;
        @(posedge clk);
        #1 sticky_clr = 1'b0;
        chk("sticky_clr_wins", 32'(sticky_flags), 32'h00);
        chk("illegal_no_enable", 32'(en_cnt), 32'(e0));

        push(3'd7, 5'd1, 5'd2, 5'd12, 32'h0, 6'b001000, 3'b000, -1, -1);
        wait_done();
        chk("sticky_inv", 32'(sticky_flags), 32'h08);
        @(negedge clk) sticky_clr = 1'b1;
        @(negedge clk) sticky_clr = 1'b0;
        chk("sticky_clr", 32'(sticky_flags), 32'h00);

        push(3'd4, 5'd0, 5'd1, 5'd6, 32'h0, 6'b000000, 3'b100, 2, -1);
        wait_done();
        chk("sram_dst_cmp", sram[6], 32'h0);

        hang = 1'b1;
        push(3'd0, 5'd0, 5'd1, 5'd13, 32'h0, 6'b100000, 3'b000, 16, -1);
        wait_done();
        hang = 1'b0;
        chk("timeout_no_write", sram[13], 32'h0BAD_F00D);
        push(3'd3, 5'd5, 5'd5, 5'd14, 32'h4000_0000, 6'b000000, 3'b000, 2, -1);
        wait_done();
        chk("after_timeout_sram", sram[14], 32'h4000_0000);

        lat = 8;
        r0 = rsp_cnt;
        push(3'd0, 5'd0, 5'd1, 5'd2, 32'h4040_0000, 6'b000000, 3'b100, 9, -1);
        push(3'd1, 5'd1, 5'd4, 5'd7, 32'h40C0_0000, 6'b000000, 3'b000, 9, -1);
        push(3'd3, 5'd5, 5'd5, 5'd8, 32'h4000_0000, 6'b000000, 3'b000, 9, -1);
        push(3'd0, 5'd0, 5'd1, 5'd9, 32'h4040_0000, 6'b000000, 3'b100, 9, -1);
        push(3'd4, 5'd4, 5'd1, 5'd10, 32'h0, 6'b000000, 3'b001, 9, -1);
        @(negedge clk);
        chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("full_busy", 32'(busy), 32'd1);
        push(3'd0, 5'd0, 5'd1, 5'd15, 32'h4040_0000, 6'b000000, 3'b100, 9, -1);
        wait_done();
        chk("full_rsp_count", 32'(rsp_cnt - r0), 32'd6);
        chk("sram_dst_mul", sram[7], 32'h40C0_0000);

        lat = 0;
        push(3'd0, 5'd0, 5'd1, 5'd16, 32'h4040_0000, 6'b000000, 3'b100, 1, -1);
        push(3'd1, 5'd1, 5'd4, 5'd17, 32'h40C0_0000, 6'b000000, 3'b000, 1, 5);
        push(3'd3, 5'd5, 5'd5, 5'd18, 32'h4000_0000, 6'b000000, 3'b000, 1, 5);
        wait_done();

        lat = 10;
        push(3'd0, 5'd0, 5'd1, 5'd19, 32'h4040_0000, 6'b000000, 3'b100, 11, -1);
        @(negedge clk) cmd_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_exec_enable", 32'({fpu_enable, fpu_ld}), 32'b10);
        #2 taprst = 1'b0;
        #1;
        sb.delete();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_enable", 32'(fpu_enable), 32'd0);
        chk("abort_addr1", 32'(fpu_addr1), 32'd31);
        r0 = rsp_cnt;
        @(negedge clk) taprst = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_no_rsp", 32'(rsp_cnt), 32'(r0));
        chk("abort_idle", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed simulation still running expected $finish before 200000");
        $fatal(1, "watchdog expired");
    end
endmodule
